sim_control_wb: RTL and testbench
=================================

Name: sim_control_wb

Overview:
- Wishbone B3 classic slave on the SoC data bus. Used only by the simulation test bench, alongside soc_top.
- Gives test firmware three services:
  - A buffered console byte stream that the bench prints.
  - A 64-bit cycle counter.
  - An exit-code register plus a reloadable watchdog, which together decide when and how the simulation ends.
- The bench consumes exit_valid_o/exit_code_o/timeout_o and calls $finish.

Parameters:
FIFO_DEPTH_LOG2, 4, console FIFO holds 2**FIFO_DEPTH_LOG2 bytes
TIMEOUT_CYCLES, 32'd100_000_000, watchdog reload value at reset; 0 means disabled

Ports:
wb_clk_i  in  1  single clock, rising edge
wb_rst_n_i  in  1  asynchronous, active-low reset
wb_adr_i  in  32  byte address; bits [4:2] decoded, others ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data, valid with ack
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
con_data_o  out  8  console byte at FIFO head
con_valid_o  out  1  FIFO not empty
con_ready_i  in  1  bench accepts byte; pop when valid&ready
exit_valid_o  out  1  sticky; firmware exit request, console drained
exit_code_o  out  8  exit code, stable while exit_valid_o
timeout_o  out  1  sticky; watchdog expired

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, cycle counter 0, watchdog = TIMEOUT_CYCLES, exit state idle. Reset mid-transfer discards the FIFO contents and any pending exit.
- Bus handshake:
  - Request = cyc&stb&~ack&~err.
  - Ack/err is registered, 1 cycle after request, high for exactly 1 cycle.
  - wb_dat_o is 0 whenever ack is low.
- Register map (word offsets):
  - 0x00 CON_TX: write with sel[0] pushes dat_i[7:0]; sel[0]=0 is acked with no push. If FIFO full, ack is withheld (wait states) until a slot frees, then push and ack in the same edge. Read returns 0.
  - 0x04 STATUS, RO: bit0 = empty, bit1 = full, bit2 = exit pending, bit3 = timeout, [15:8] = FIFO level (0..2**FIFO_DEPTH_LOG2). Writes are acked and ignored.
  - 0x08 EXIT, WO: first write latches dat_i[7:0] into exit_code_o and sets pending. Later writes are acked and ignored. Read returns 0.
  - 0x0C CYCLE_LO, RO: returns counter[31:0] and snapshots counter[63:32] in the same edge.
  - 0x10 CYCLE_HI, RO: returns the snapshot, so lo-then-hi reads are coherent.
  - 0x14 WDOG, RW: write loads the counter with dat_i (all 4 sel required, else err); 0 disables. Read returns the current value.
  - 0x18, 0x1C: err.
- Console FIFO:
  - Pop on con_valid_o&con_ready_i; con_data_o is head, registered, first-word-fall-through.
  - Push and pop in the same cycle: level unchanged.
  - A push blocked when full waits for the cycle after the pop; it is not accepted in the pop cycle.
  - Pointers are FIFO_DEPTH_LOG2+1 bits and wrap naturally.
- Exit: exit_valid_o rises on the first edge where pending=1 and FIFO empty with no push in progress. It stays high until reset.
- Cycle counter: 64-bit, +1 every cycle, wraps to 0.
- Watchdog:
  - If the value is nonzero, not timed out and exit not pending: decrement each cycle.
  - Transition 1->0 by decrement sets timeout_o (sticky).
  - A WDOG write in the same cycle as the decrement wins.
  - After timeout, writes still update the value but timeout_o stays 1.
- exit_valid_o and timeout_o may both be 1; the bench gives timeout priority.

Decomposition:
- Package sim_control_pkg holds:
  - Register offset constants (CON_TX..WDOG).
  - STATUS bit positions.
  - Localparam widths.
- Sub-module sim_control_fifo: synchronous FIFO, parameter DEPTH_LOG2, 8-bit data, ports push/pop/full/empty/level/head.
- Top: bus decode, registers, counters, exit/watchdog logic.

Test Plan:
- Reset, no bus activity; then read STATUS after 3 cycles -> all outputs 0 during reset; STATUS = 0x0000_0001, ack exactly 1 cycle after stb.
- Write 'H','i' to CON_TX with con_ready_i=0, then raise ready -> STATUS[15:8]=2; con_data_o=0x48 then 0x69 on consecutive cycles; STATUS returns to empty.
- Hold ready=0, write 17 bytes (depth 16) -> 17th write stalls; raise ready for 1 cycle -> 17th acked on the following edge; level = 16.
- Write 0x2A to EXIT with 3 bytes queued, ready=1 -> exit_valid_o rises the edge after the last pop; exit_code_o=0x2A; a second EXIT write of 0x01 leaves the code at 0x2A.
- Write WDOG=5, idle -> timeout_o=1 exactly 5 cycles after the ack edge; WDOG=0 on a fresh run -> no timeout over 1000 cycles.
- Read CYCLE_LO then CYCLE_HI with the counter preset near 0xFFFF_FFFF (force) -> HI reflects the pre-carry value; read 0x18 -> wb_err_o=1, wb_ack_o=0.

Source files
------------

// File: rtl/sim_control_pkg.sv
// Shared constants and types for the simulation control Wishbone slave.
package sim_control_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CYCLE_W = 64;
  localparam int unsigned ADDR_W  = 3;

  // Word-offset register indices (wb_adr_i[4:2])
  localparam logic [ADDR_W-1:0] REG_CON_TX   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd1;
  localparam logic [ADDR_W-1:0] REG_EXIT     = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CYCLE_LO = 3'd3;
  localparam logic [ADDR_W-1:0] REG_CYCLE_HI = 3'd4;
  localparam logic [ADDR_W-1:0] REG_WDOG     = 3'd5;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EXIT      = 2;
  localparam int unsigned ST_TIMEOUT   = 3;
  localparam int unsigned ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    EXIT_IDLE,
    EXIT_PENDING,
    EXIT_DONE
  } exit_state_t;

endpackage

// File: rtl/sim_control_fifo.sv
// Byte FIFO for the console stream; head is presented fall-through from storage.
module sim_control_fifo
  import sim_control_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [BYTE_W-1:0]     push_data,
  input  logic                  pop,
  output logic [BYTE_W-1:0]     head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BYTE_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == FULL_LEVEL);
  // Head forced to zero when empty so the output is clean out of reset
  assign head    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; extra MSB distinguishes full from empty and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/sim_control_wb.sv
// Simulation control slave: console FIFO, cycle counter, exit register, watchdog.
module sim_control_wb
  import sim_control_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100_000_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        exit_valid_o,
  output logic [7:0]  exit_code_o,
  output logic        timeout_o
);

  logic [ADDR_W-1:0]        addr;
  logic                     req;
  logic                     tx_req;
  logic                     push;
  logic                     stall;
  logic                     bad;
  logic                     ack_next;
  logic                     err_next;
  logic                     exit_wr;
  logic                     wdog_wr;
  logic                     lo_rd;
  logic [DATA_W-1:0]        rdata;
  logic [DATA_W-1:0]        status;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  logic [CYCLE_W-1:0]       cycle_cnt;
  logic [DATA_W-1:0]        cycle_hi_snap;
  logic [DATA_W-1:0]        wdog;
  logic                     pending;
  exit_state_t              exit_state;
  exit_state_t              exit_next;
  logic                     unused_adr;

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  assign addr   = wb_adr_i[4:2];
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign tx_req = req & wb_we_i & (addr == REG_CON_TX) & wb_sel_i[0];
  // Full FIFO holds the request in wait states; push and ack happen on the same edge
  assign push   = tx_req & ~fifo_full;
  assign stall  = tx_req & fifo_full;
  assign bad    = (addr > REG_WDOG) |
                  ((addr == REG_WDOG) & wb_we_i & (wb_sel_i != 4'hF));
  assign ack_next = req & ~bad & ~stall;
  assign err_next = req & bad;
  assign exit_wr  = ack_next & wb_we_i & (addr == REG_EXIT);
  assign wdog_wr  = ack_next & wb_we_i & (addr == REG_WDOG);
  assign lo_rd    = ack_next & ~wb_we_i & (addr == REG_CYCLE_LO);
  assign pending  = (exit_state != EXIT_IDLE);

  sim_control_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (push),
    .push_data (wb_dat_i[7:0]),
    .pop       (con_ready_i),
    .head      (con_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign con_valid_o = ~fifo_empty;

  // STATUS word assembly
  always_comb begin
    status                              = '0;
    status[ST_EMPTY]                    = fifo_empty;
    status[ST_FULL]                     = fifo_full;
    status[ST_EXIT]                     = pending;
    status[ST_TIMEOUT]                  = timeout_o;
    status[ST_LEVEL_LSB +: BYTE_W]      = 8'(fifo_level);
  end

  // Read data mux; write-only and unmapped locations read as zero
  always_comb begin
    rdata = '0;
    if (!wb_we_i) begin
      case (addr)
        REG_STATUS:   rdata = status;
        REG_CYCLE_LO: rdata = cycle_cnt[31:0];
        REG_CYCLE_HI: rdata = cycle_hi_snap;
        REG_WDOG:     rdata = wdog;
        default:      rdata = '0;
      endcase
    end
  end

  // Registered bus response, one cycle wide
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= ack_next;
      wb_err_o <= err_next;
      wb_dat_o <= ack_next ? rdata : '0;
    end
  end

  // Free-running cycle counter and high-word snapshot taken on CYCLE_LO reads
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cycle_cnt     <= '0;
      cycle_hi_snap <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (lo_rd) cycle_hi_snap <= cycle_cnt[63:32];
    end
  end

  // Watchdog: bus write beats the decrement; expiry is sticky
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wdog      <= TIMEOUT_CYCLES;
      timeout_o <= 1'b0;
    end else if (wdog_wr) begin
      wdog <= wb_dat_i;
    end else if ((wdog != '0) && !timeout_o && !pending) begin
      wdog <= wdog - 32'd1;
      if (wdog == 32'd1) timeout_o <= 1'b1;
    end
  end

  // Exit state register and latched exit code
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      exit_state  <= EXIT_IDLE;
      exit_code_o <= '0;
    end else begin
      exit_state <= exit_next;
      if (exit_wr && (exit_state == EXIT_IDLE)) exit_code_o <= wb_dat_i[7:0];
    end
  end

  // Exit next-state: completes once the console has drained with nothing in flight
  always_comb begin
    exit_next = exit_state;
    case (exit_state)
      EXIT_IDLE:    if (exit_wr) exit_next = EXIT_PENDING;
      EXIT_PENDING: if (fifo_empty && !tx_req) exit_next = EXIT_DONE;
      EXIT_DONE:    exit_next = EXIT_DONE;
      default:      exit_next = EXIT_IDLE;
    endcase
  end

  assign exit_valid_o = (exit_state == EXIT_DONE);

endmodule

// File: tb/tb_sim_control_wb.sv
// Directed bench for sim_control_wb with immediate-assertion checks.
module tb_sim_control_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [7:0]  con_data_o;
  logic        con_valid_o;
  logic        con_ready = 1'b0;
  logic        exit_valid_o;
  logic [7:0]  exit_code_o;
  logic        timeout_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        ack;
  logic        err;
  int          ncyc;

  sim_control_wb #(
    .FIFO_DEPTH_LOG2 (4),
    .TIMEOUT_CYCLES  (32'd100_000_000)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_err_o     (wb_err_o),
    .con_data_o   (con_data_o),
    .con_valid_o  (con_valid_o),
    .con_ready_i  (con_ready),
    .exit_valid_o (exit_valid_o),
    .exit_code_o  (exit_code_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; gives up after 64 cycles with ack=err=0
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata,
                         output logic ackd, output logic errd, output int cycles);
    wb_adr = adr;
    wb_we  = we;
    wb_dat = dat;
    wb_sel = sel;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!wb_ack_o && !wb_err_o && cycles < 64);
    rdata  = wb_dat_o;
    ackd   = wb_ack_o;
    errd   = wb_err_o;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {11'd0, wb_ack_o, wb_err_o, wb_dat_o, con_data_o, con_valid_o,
            exit_valid_o, exit_code_o, timeout_o};
  endfunction

  initial begin
    // Reset and idle status
    tick(3);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick(3);
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_after_reset", rd, 32'h0000_0001);
    check("status_ack_err", {ack, err}, 2'b10);
    check("status_ack_latency", 64'(ncyc), 64'd1);
    tick(1);
    check("ack_single_cycle", {wb_ack_o, wb_dat_o}, 33'd0);

    // Two console bytes, then drain
    wb_xfer(32'h00, 1'b1, 32'h48, 4'h1, rd, ack, err, ncyc);
    wb_xfer(32'h00, 1'b1, 32'h69, 4'h1, rd, ack, err, ncyc);
    wb_xfer(32'h00, 1'b1, 32'h77, 4'hE, rd, ack, err, ncyc);
    check("con_tx_nosel_ack", {ack, err}, 2'b10);
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_level2", rd, 32'h0000_0200);
    check("con_head_H", {con_valid_o, con_data_o}, 9'h148);
    con_ready = 1'b1;
    tick(1);
    check("con_head_i", {con_valid_o, con_data_o}, 9'h169);
    tick(1);
    check("con_drained", {con_valid_o, con_data_o}, 9'h000);
    con_ready = 1'b0;
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_empty_again", rd, 32'h0000_0001);
    wb_xfer(32'h00, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("con_tx_read_zero", {ack, rd}, {1'b1, 32'h0});

    // Fill to 16, 17th write stalls until one pop frees a slot
    for (int i = 0; i < 16; i++)
      wb_xfer(32'h00, 1'b1, 32'h10 + 32'(i), 4'h1, rd, ack, err, ncyc);
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_full", rd, 32'h0000_1002);
    wb_adr = 32'h00; wb_we = 1'b1; wb_dat = 32'hAA; wb_sel = 4'h1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    tick(3);
    check("tx_stall_while_full", {wb_ack_o, wb_err_o}, 2'b00);
    con_ready = 1'b1;
    tick(1);
    con_ready = 1'b0;
    check("tx_not_in_pop_cycle", {wb_ack_o, wb_err_o}, 2'b00);
    tick(1);
    check("tx_ack_after_pop", {wb_ack_o, wb_err_o}, 2'b10);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_full_after_17", rd, 32'h0000_1002);
    check("head_after_one_pop", con_data_o, 8'h11);
    con_ready = 1'b1;
    tick(20);
    check("drain_full_fifo", con_valid_o, 1'b0);
    con_ready = 1'b0;

    // Exit waits for the console to drain
    for (int i = 0; i < 3; i++)
      wb_xfer(32'h00, 1'b1, 32'h30 + 32'(i), 4'h1, rd, ack, err, ncyc);
    wb_xfer(32'h08, 1'b1, 32'h2A, 4'hF, rd, ack, err, ncyc);
    check("exit_wait_queued", exit_valid_o, 1'b0);
    con_ready = 1'b1;
    tick(3);
    check("exit_not_at_last_pop", {con_valid_o, exit_valid_o}, 2'b00);
    tick(1);
    check("exit_valid_after_drain", {exit_valid_o, exit_code_o}, 9'h12A);
    con_ready = 1'b0;
    wb_xfer(32'h08, 1'b1, 32'h01, 4'hF, rd, ack, err, ncyc);
    check("exit_second_write_ignored", {ack, exit_valid_o, exit_code_o}, 10'h32A);
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_exit_pending", rd, 32'h0000_0005);

    // Reset discards exit state
    rst_n = 1'b0;
    tick(1);
    check("reset_clears_exit", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick(1);
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_after_rereset", rd, 32'h0000_0001);

    // Watchdog of 5 expires 5 edges after the write ack
    wb_xfer(32'h14, 1'b1, 32'd5, 4'hF, rd, ack, err, ncyc);
    tick(4);
    check("wdog_not_yet", timeout_o, 1'b0);
    tick(1);
    check("wdog_expired", timeout_o, 1'b1);
    wb_xfer(32'h14, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("wdog_read_zero", {ack, rd}, {1'b1, 32'h0});
    wb_xfer(32'h04, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("status_timeout", rd, 32'h0000_0009);
    wb_xfer(32'h14, 1'b1, 32'd9, 4'h3, rd, ack, err, ncyc);
    check("wdog_partial_sel_err", {ack, err, rd}, {2'b01, 32'h0});
    wb_xfer(32'h14, 1'b1, 32'd7, 4'hF, rd, ack, err, ncyc);
    wb_xfer(32'h14, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("wdog_write_after_timeout", {timeout_o, rd}, {1'b1, 32'd7});

    // Watchdog disabled
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    wb_xfer(32'h14, 1'b1, 32'd0, 4'hF, rd, ack, err, ncyc);
    tick(1000);
    check("wdog_disabled", timeout_o, 1'b0);

    // Coherent 64-bit counter read across a low-word carry
    force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFE;
    tick(1);
    release dut.cycle_cnt;
    wb_xfer(32'h0C, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("cycle_lo", {ack, rd}, {1'b1, 32'hFFFF_FFFE});
    wb_xfer(32'h10, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("cycle_hi_snapshot", {ack, rd}, {1'b1, 32'h0000_0005});

    // Unmapped offsets terminate with err
    wb_xfer(32'h18, 1'b0, '0, 4'hF, rd, ack, err, ncyc);
    check("unmapped_18_err", {ack, err, rd}, {2'b01, 32'h0});
    wb_xfer(32'h1C, 1'b1, 32'h55, 4'hF, rd, ack, err, ncyc);
    check("unmapped_1c_err", {ack, err}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
